// File: rtl/bcd_countdown_timer.sv
// ============================================================================
// bcd_countdown_timer : MM:SS BCD countdown with load/clear, pause and done pulse
// Revision 1.0
// ============================================================================
`default_nettype none

module bcd_countdown_timer #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] ClearUS,
  input  logic [3:0] ClearDS,
  input  logic [3:0] ClearUM,
  input  logic [3:0] ClearDM,
  input  logic [3:0] PresetUS,
  input  logic [3:0] PresetDS,
  input  logic [3:0] PresetUM,
  input  logic [3:0] PresetDM,
  output logic [3:0] US,
  output logic [3:0] DS,
  output logic [3:0] UM,
  output logic [3:0] DM,
  output logic       running,
  output logic       done,
  output logic       zero
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] c_tick_last = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  logic [3:0]    r_us, r_ds, r_um, r_dm;
  logic [PW-1:0] r_presc;
  logic          r_start_q;
  logic          r_running;
  logic          r_done;

  logic          w_start_edge;
  logic          w_tick;
  logic [3:0]    w_us_n, w_ds_n, w_um_n, w_dm_n;
  logic          w_dec_zero;

  function automatic logic [3:0] sat(input logic [3:0] v, input logic [3:0] m);
    return (v > m) ? m : v;
  endfunction

  assign w_start_edge = start & ~r_start_q;
  assign w_tick       = (r_presc == c_tick_last);
  assign zero         = (r_us == 4'd0) && (r_ds == 4'd0) && (r_um == 4'd0) && (r_dm == 4'd0);

  // Borrow chain; a zero count holds so 00:00 stays terminal.
  always_comb begin
    w_us_n = r_us;
    w_ds_n = r_ds;
    w_um_n = r_um;
    w_dm_n = r_dm;
    if (!zero) begin
      if (r_us != 4'd0) begin
        w_us_n = r_us - 4'd1;
      end else begin
        w_us_n = 4'd9;
        if (r_ds != 4'd0) begin
          w_ds_n = r_ds - 4'd1;
        end else begin
          w_ds_n = 4'd5;
          if (r_um != 4'd0) begin
            w_um_n = r_um - 4'd1;
          end else begin
            w_um_n = 4'd9;
            if (r_dm != 4'd0) w_dm_n = r_dm - 4'd1;
          end
        end
      end
    end
  end

  assign w_dec_zero = (w_us_n == 4'd0) && (w_ds_n == 4'd0) && (w_um_n == 4'd0) && (w_dm_n == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_us      <= 4'd0;
      r_ds      <= 4'd0;
      r_um      <= 4'd0;
      r_dm      <= 4'd0;
      r_presc   <= '0;
      r_start_q <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_start_q <= start;
      r_done    <= 1'b0;
      if (clear || load) begin
        r_us      <= clear ? sat(ClearUS, 4'd9) : sat(PresetUS, 4'd9);
        r_ds      <= clear ? sat(ClearDS, 4'd5) : sat(PresetDS, 4'd5);
        r_um      <= clear ? sat(ClearUM, 4'd9) : sat(PresetUM, 4'd9);
        r_dm      <= clear ? sat(ClearDM, 4'd9) : sat(PresetDM, 4'd9);
        r_presc   <= '0;
        r_state   <= S_IDLE;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!pause && w_start_edge && !zero) begin
              r_presc   <= '0;
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          S_RUN: begin
            // Prescaler holds its phase across a pause.
            if (pause) begin
              r_state   <= S_PAUSED;
              r_running <= 1'b0;
            end else if (w_tick) begin
              r_presc <= '0;
              r_us    <= w_us_n;
              r_ds    <= w_ds_n;
              r_um    <= w_um_n;
              r_dm    <= w_dm_n;
              if (w_dec_zero) begin
                r_state   <= S_DONE;
                r_running <= 1'b0;
                r_done    <= 1'b1;
              end
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
          S_PAUSED: begin
            if (!pause) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign US      = r_us;
  assign DS      = r_ds;
  assign UM      = r_um;
  assign DM      = r_dm;
  assign running = r_running;
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
// ============================================================================
// tb_bcd_countdown_timer : directed self-checking bench for bcd_countdown_timer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [3:0] ClearUS = 4'd0, ClearDS = 4'd0, ClearUM = 4'd0, ClearDM = 4'd0;
  logic [3:0] PresetUS = 4'd0, PresetDS = 4'd0, PresetUM = 4'd0, PresetDM = 4'd0;
  logic [3:0] US, DS, UM, DM;
  logic       running, done, zero;

  int checks = 0;
  int errors = 0;

  bcd_countdown_timer #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .start(start), .pause(pause),
    .ClearUS(ClearUS), .ClearDS(ClearDS), .ClearUM(ClearUM), .ClearDM(ClearDM),
    .PresetUS(PresetUS), .PresetDS(PresetDS), .PresetUM(PresetUM), .PresetDM(PresetDM),
    .US(US), .DS(DS), .UM(UM), .DM(DM),
    .running(running), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [3:0] dm, input logic [3:0] um, input logic [3:0] ds, input logic [3:0] us);
    PresetDM = dm; PresetUM = um; PresetDS = ds; PresetUS = us;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_digits", {DM, UM, DS, US}, 16'h0000);
    check("rst_flags", {13'd0, running, done, zero}, 16'h0001);
    step(1);
    rst_n = 1'b1;
    step(1);

    // 00:10 countdown to done
    preset(4'd0, 4'd0, 4'd1, 4'd0);
    check("load_0010", {DM, UM, DS, US}, 16'h0010);
    kick();
    check("run_entered", {15'd0, running}, 16'h0001);
    step(3);
    check("before_tick1", {DM, UM, DS, US}, 16'h0010);
    step(1);
    check("tick1_0009", {DM, UM, DS, US}, 16'h0009);
    step(35);
    check("t39_0001", {DM, UM, DS, US}, 16'h0001);
    check("t39_nodone", {15'd0, done}, 16'h0000);
    step(1);
    check("t40_0000", {DM, UM, DS, US}, 16'h0000);
    check("t40_flags", {13'd0, running, done, zero}, 16'h0003);
    step(1);
    check("done_one_cycle", {13'd0, running, done, zero}, 16'h0001);
    kick();
    step(5);
    check("done_ignores_start", {12'd0, running, done, zero, 1'b0}, 16'h0002);
    check("done_holds", {DM, UM, DS, US}, 16'h0000);

    // Full borrow chain 10:00 -> 09:59
    preset(4'd1, 4'd0, 4'd0, 4'd0);
    kick();
    step(4);
    check("borrow_0959", {DM, UM, DS, US}, 16'h0959);

    // Load sanitising (also a load while running)
    preset(4'd3, 4'd15, 4'd7, 4'd12);
    check("sanitize_preset", {DM, UM, DS, US}, 16'h3959);
    check("load_stops_run", {15'd0, running}, 16'h0000);
    ClearDM = 4'hF; ClearUM = 4'd2; ClearDS = 4'd9; ClearUS = 4'hA;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("sanitize_clear", {DM, UM, DS, US}, 16'h9259);

    // Pause mid-second keeps prescaler phase
    preset(4'd0, 4'd0, 4'd0, 4'd5);
    kick();
    step(2);
    pause = 1'b1;
    step(1);
    check("paused_running", {15'd0, running}, 16'h0000);
    step(19);
    check("paused_frozen", {DM, UM, DS, US}, 16'h0005);
    pause = 1'b0;
    step(1);
    check("resumed_running", {15'd0, running}, 16'h0001);
    step(1);
    check("resume_partial_a", {DM, UM, DS, US}, 16'h0005);
    step(1);
    check("resume_partial_b", {DM, UM, DS, US}, 16'h0004);

    // Start with zero count is ignored
    preset(4'd0, 4'd0, 4'd0, 4'd0);
    kick();
    step(4);
    check("zero_start_ignored", {13'd0, running, done, zero}, 16'h0001);

    // Load on the tick cycle wins and resets the prescaler
    preset(4'd0, 4'd0, 4'd0, 4'd5);
    kick();
    step(3);
    preset(4'd0, 4'd0, 4'd3, 4'd0);
    check("load_over_tick", {DM, UM, DS, US}, 16'h0030);
    check("load_over_tick_idle", {15'd0, running}, 16'h0000);
    kick();
    step(3);
    check("presc_reset_a", {DM, UM, DS, US}, 16'h0030);
    step(1);
    check("presc_reset_b", {DM, UM, DS, US}, 16'h0029);

    // Pause beats start edge in IDLE; held start does not re-trigger
    preset(4'd0, 4'd0, 4'd0, 4'd3);
    pause = 1'b1;
    start = 1'b1;
    step(1);
    check("pause_over_start", {15'd0, running}, 16'h0000);
    pause = 1'b0;
    step(2);
    check("held_start_no_retrigger", {15'd0, running}, 16'h0000);
    start = 1'b0;
    step(1);
    kick();
    check("fresh_edge_runs", {15'd0, running}, 16'h0001);

    // Clear in DONE reloads without a done pulse
    preset(4'd0, 4'd0, 4'd0, 4'd1);
    kick();
    step(4);
    check("done_from_0001", {12'd0, running, done, zero, 1'b0}, 16'h0006);
    ClearDM = 4'd0; ClearUM = 4'd0; ClearDS = 4'd0; ClearUS = 4'd2;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_in_done", {DM, UM, DS, US}, 16'h0002);
    check("clear_in_done_flags", {13'd0, running, done, zero}, 16'h0000);

    // Asynchronous reset while running at 12:34
    preset(4'd1, 4'd2, 4'd3, 4'd4);
    kick();
    step(2);
    check("pre_reset_run", {15'd0, running}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("async_rst_digits", {DM, UM, DS, US}, 16'h0000);
    check("async_rst_flags", {13'd0, running, done, zero}, 16'h0001);
    step(1);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
